// File: rtl/cpu_sequencer_if.sv
// Memory and ALU connection bundle for cpu_sequencer.
// The sequencer is the master: it drives addresses, store data and the
// operand registers; memory/ALU (slave) return read data, result and flags.
interface cpu_sequencer_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] alu_opcode;
    logic [7:0] alu_value;
    logic [7:0] alu_mdr;
    logic [7:0] ac;
    logic [7:0] alu_z;
    logic       nflg;
    logic       zflg;

    modport master (
        output mem_addr, mem_wdata, mem_we, alu_opcode, alu_value, alu_mdr, ac,
        input  mem_rdata, alu_z, nflg, zflg
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, alu_opcode, alu_value, alu_mdr, ac,
        output mem_rdata, alu_z, nflg, zflg
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Accumulator CPU sequencer: two-byte fetch (opcode, operand), optional
// memory-operand read, then execute (AC load, store, or branch). The ALU is
// external; this block only sequences and holds architectural registers.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    cpu_sequencer_if.master bus,
    output logic [7:0]      pc,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_FETCH1 = 3'd0,
        S_FETCH2 = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pc, r_ir, r_opr, r_mdr, r_ac;
    logic [7:0] w_pc_nxt, w_ir_nxt, w_opr_nxt, w_mdr_nxt, w_ac_nxt;
    logic [7:0] w_addr;
    logic       w_we;
    logic       w_is_mem;
    logic       w_writes_ac;

    // Opcode decode: which instructions need a memory operand, which load AC.
    always_comb begin
        w_is_mem    = 1'b0;
        w_writes_ac = 1'b0;
        case (r_ir)
            8'h01, 8'h05, 8'h07, 8'h09,
            8'h0A, 8'h0B, 8'h0C, 8'h0D: w_is_mem = 1'b1;
            default:                     w_is_mem = 1'b0;
        endcase
        if (r_ir == 8'h01 || r_ir == 8'h02 || (r_ir >= 8'h04 && r_ir <= 8'h0F))
            w_writes_ac = 1'b1;
    end

    // Next-state and datapath update; all registers hold unless a state moves them.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_opr_nxt   = r_opr;
        w_mdr_nxt   = r_mdr;
        w_ac_nxt    = r_ac;
        w_addr      = r_pc;
        w_we        = 1'b0;
        case (r_state)
            S_FETCH1: begin
                if (run) begin
                    w_ir_nxt    = bus.mem_rdata;
                    w_pc_nxt    = r_pc + 8'd1;
                    w_state_nxt = S_FETCH2;
                end
            end
            S_FETCH2: begin
                w_opr_nxt = bus.mem_rdata;
                w_pc_nxt  = r_pc + 8'd1;
                if (r_ir == 8'hFF)
                    w_state_nxt = S_HALT;
                else if (w_is_mem)
                    w_state_nxt = S_READ;
                else
                    w_state_nxt = S_EXEC;
            end
            S_READ: begin
                w_addr      = r_opr;
                w_mdr_nxt   = bus.mem_rdata;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_addr      = r_opr;
                w_state_nxt = S_FETCH1;
                if (w_writes_ac)
                    w_ac_nxt = bus.alu_z;
                case (r_ir)
                    // A reset landing on this cycle must not let the store escape.
                    8'h03: w_we = ~reset;
                    8'h10: w_pc_nxt = r_opr;
                    8'h11: if (bus.nflg) w_pc_nxt = r_opr;
                    8'h12: if (bus.zflg) w_pc_nxt = r_opr;
                    default: ;
                endcase
            end
            S_HALT: ;
            default: w_state_nxt = S_FETCH1;
        endcase
    end

    // State and register update; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH1;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_opr   <= 8'h00;
            r_mdr   <= 8'h00;
            r_ac    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_opr   <= w_opr_nxt;
            r_mdr   <= w_mdr_nxt;
            r_ac    <= w_ac_nxt;
        end
    end

    assign bus.mem_addr   = w_addr;
    assign bus.mem_wdata  = r_ac;
    assign bus.mem_we     = w_we;
    assign bus.alu_opcode = r_ir;
    assign bus.alu_value  = r_opr;
    assign bus.alu_mdr    = r_mdr;
    assign bus.ac         = r_ac;
    assign pc             = r_pc;
    assign halted         = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed program scenarios plus random programs
// checked against an instruction-level interpreter with per-instruction
// cycle counts.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic reset, run, run2;
    logic [7:0] pc, pc2;
    logic halted, halted2;

    always #5 clk = ~clk;

    cpu_sequencer_if bif ();
    cpu_sequencer_if bif2 ();

    cpu_sequencer #(.RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .run(run), .bus(bif.master), .pc(pc), .halted(halted)
    );
    cpu_sequencer #(.RESET_PC(8'hFF)) u_dut2 (
        .clk(clk), .reset(reset), .run(run2), .bus(bif2.master), .pc(pc2), .halted(halted2)
    );

    // Environment ALU: operation chosen for each defined AC-loading opcode.
    function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] v, input logic [7:0] m);
        case (op)
            8'h01: return m;
            8'h02: return v;
            8'h04: return a & v;
            8'h05: return a + m;
            8'h06: return a + v;
            8'h07: return a - m;
            8'h08: return a - v;
            8'h09: return a & m;
            8'h0A: return a | m;
            8'h0B: return a ^ m;
            8'h0C: return ~m;
            8'h0D: return m + 8'd1;
            8'h0E: return a | v;
            8'h0F: return a ^ v;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] mem  [256];
    logic [7:0] mem2 [256];
    logic [7:0] mm   [256];

    assign bif.mem_rdata  = mem[bif.mem_addr];
    assign bif.alu_z      = alu_f(bif.alu_opcode, bif.ac, bif.alu_value, bif.alu_mdr);
    assign bif.nflg       = bif.ac[7];
    assign bif.zflg       = (bif.ac == 8'h00);
    assign bif2.mem_rdata = mem2[bif2.mem_addr];
    assign bif2.alu_z     = alu_f(bif2.alu_opcode, bif2.ac, bif2.alu_value, bif2.alu_mdr);
    assign bif2.nflg      = bif2.ac[7];
    assign bif2.zflg      = (bif2.ac == 8'h00);

    always @(posedge clk) begin
        if (bif.mem_we)  mem[bif.mem_addr]   <= bif.mem_wdata;
        if (bif2.mem_we) mem2[bif2.mem_addr] <= bif2.mem_wdata;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem[a] <= d;
        mm[a]  = d;
    endtask

    // Reset the DUT and clear memory; returns at a negedge with reset released.
    task automatic reset_clear();
        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
        step(1);
        reset = 1'b0;
    endtask

    function automatic bit is_mem_op(input logic [7:0] op);
        return op == 8'h01 || op == 8'h05 || op == 8'h07 || op == 8'h09 ||
               (op >= 8'h0A && op <= 8'h0D);
    endfunction

    // Instruction-level interpreter; DUT is checked cycle by cycle for the
    // store strobe and at every instruction boundary for PC and AC.
    task automatic run_prog(input int max_ins);
        logic [7:0] mpc, mac, op, opr, mdr;
        int ncyc;
        bit done;
        mpc = 8'h00; mac = 8'h00; done = 1'b0;
        run = 1'b1;
        for (int k = 0; k < max_ins && !done; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                run = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    step(1);
                    chk("stall_pc", pc, mpc);
                    chk("stall_ac", bif.ac, mac);
                    chk("stall_we", bif.mem_we, 0);
                end
                run = 1'b1;
            end
            op  = mm[mpc];
            opr = mm[mpc + 8'd1];
            ncyc = (op == 8'hFF) ? 2 : (is_mem_op(op) ? 4 : 3);
            for (int c = 0; c < ncyc; c++) begin
                chk("rnd_we", bif.mem_we, (op == 8'h03 && c == 2) ? 1 : 0);
                if (op == 8'h03 && c == 2) begin
                    chk("rnd_waddr", bif.mem_addr, opr);
                    chk("rnd_wdata", bif.mem_wdata, mac);
                end
                chk("rnd_halted", halted, 0);
                step(1);
            end
            mdr = mm[opr];
            mpc = mpc + 8'd2;
            if (op == 8'h01 || op == 8'h02 || (op >= 8'h04 && op <= 8'h0F))
                mac = alu_f(op, mac, opr, mdr);
            else if (op == 8'h03) mm[opr] = mac;
            else if (op == 8'h10) mpc = opr;
            else if (op == 8'h11 && mac[7]) mpc = opr;
            else if (op == 8'h12 && mac == 8'h00) mpc = opr;
            chk("rnd_pc", pc, mpc);
            chk("rnd_ac", bif.ac, mac);
            if (op == 8'hFF) begin
                chk("rnd_halt", halted, 1);
                step(3);
                chk("rnd_halt_hold", halted, 1);
                chk("rnd_halt_pc", pc, mpc);
                done = 1'b1;
            end
        end
        run = 1'b0;
    endtask

    task automatic load_demo();
        poke(8'h00, 8'h02); poke(8'h01, 8'h05);
        poke(8'h02, 8'h06); poke(8'h03, 8'h03);
        poke(8'h04, 8'h03); poke(8'h05, 8'h20);
        poke(8'h06, 8'hFF); poke(8'h07, 8'h00);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        reset = 1'b1; run = 1'b0; run2 = 1'b0;
        for (int i = 0; i < 256; i++) mem2[i] <= 8'h00;
        mem2[8'hFF] <= 8'h02; mem2[8'h00] <= 8'h7F;
        mem2[8'h01] <= 8'h13; mem2[8'h02] <= 8'h55;
        mem2[8'h03] <= 8'hFF;
        reset_clear();

        chk("rst_pc", pc, 8'h00);
        chk("rst_ac", bif.ac, 8'h00);
        chk("rst_halted", halted, 0);
        chk("rst_we", bif.mem_we, 0);
        chk("rst_ir", bif.alu_opcode, 8'h00);
        chk("rst_pc2", pc2, 8'hFF);

        // Fetch wrap from FF, then an undefined opcode.
        run2 = 1'b1;
        step(3);
        chk("wrap_ac", bif2.ac, 8'h7F);
        chk("wrap_pc", pc2, 8'h01);
        step(3);
        chk("undef_ac", bif2.ac, 8'h7F);
        chk("undef_pc", pc2, 8'h03);
        chk("undef_halted", halted2, 0);
        run2 = 1'b0;

        // Load/add/store/halt demo program.
        reset_clear();
        poke(8'h20, 8'hAA);
        load_demo();
        run = 1'b1;
        step(8);
        chk("demo_we", bif.mem_we, 1);
        chk("demo_waddr", bif.mem_addr, 8'h20);
        chk("demo_wdata", bif.mem_wdata, 8'h08);
        step(2);
        chk("demo_pre_halt", halted, 0);
        step(1);
        chk("demo_halted", halted, 1);
        chk("demo_pc", pc, 8'h08);
        chk("demo_ac", bif.ac, 8'h08);
        chk("demo_mem20", mem[8'h20], 8'h08);
        step(4);
        chk("demo_halt_hold", halted, 1);
        chk("demo_halt_we", bif.mem_we, 0);
        run = 1'b0;

        // Same program after a 5-cycle stall.
        reset_clear();
        load_demo();
        step(5);
        chk("stall_pc0", pc, 8'h00);
        chk("stall_ac0", bif.ac, 8'h00);
        run = 1'b1;
        step(11);
        chk("stall_halted", halted, 1);
        chk("stall_demo_ac", bif.ac, 8'h08);
        chk("stall_demo_mem", mem[8'h20], 8'h08);

        // Memory operand load and add, negative result.
        reset_clear();
        poke(8'h30, 8'hFE);
        poke(8'h00, 8'h01); poke(8'h01, 8'h30);
        poke(8'h02, 8'h05); poke(8'h03, 8'h30);
        run = 1'b1;
        step(4);
        chk("memop_ac1", bif.ac, 8'hFE);
        step(4);
        chk("memop_ac2", bif.ac, 8'hFC);
        chk("memop_nflg", bif.ac[7], 1);
        run = 1'b0;

        // JZ taken and not taken.
        reset_clear();
        poke(8'h00, 8'h04); poke(8'h01, 8'h00);
        poke(8'h02, 8'h12); poke(8'h03, 8'h40);
        run = 1'b1;
        step(6);
        chk("jz_taken_pc", pc, 8'h40);
        reset_clear();
        poke(8'h00, 8'h02); poke(8'h01, 8'h01);
        poke(8'h02, 8'h12); poke(8'h03, 8'h40);
        run = 1'b1;
        step(6);
        chk("jz_not_pc", pc, 8'h04);

        // Reset landing on the EXEC cycle of a store.
        reset_clear();
        poke(8'h20, 8'hAA);
        poke(8'h00, 8'h02); poke(8'h01, 8'h33);
        poke(8'h02, 8'h03); poke(8'h03, 8'h20);
        run = 1'b1;
        step(3);
        chk("abort_ac_pre", bif.ac, 8'h33);
        step(2);
        reset = 1'b1;
        #1;
        chk("abort_we", bif.mem_we, 0);
        step(1);
        reset = 1'b0; run = 1'b0;
        chk("abort_pc", pc, 8'h00);
        chk("abort_ac", bif.ac, 8'h00);
        chk("abort_fetch1", bif.mem_addr, 8'h00);
        chk("abort_mem", mem[8'h20], 8'hAA);
        step(2);
        chk("abort_hold_pc", pc, 8'h00);

        // Random programs against the interpreter.
        for (int p = 0; p < 12; p++) begin
            reset_clear();
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3)       b = 8'hFF;
                else if (r < 75) b = 8'($urandom_range(0, 19));
                else             b = 8'($urandom);
                poke(8'(i), b);
            end
            step(1);
            run_prog(80);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: RESET_PC, 8'h00, PC value loaded on reset.
REQ-002 Clock and reset: one clock, clk; reset is synchronous and active-high, port reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 run  input  1  start enable, sampled only in FETCH1; low holds FETCH1.
REQ-006 mem_addr  output  8  unified instruction/data memory address.
REQ-007 mem_rdata  input  8  memory read data, combinational from mem_addr with no latency.
REQ-008 mem_wdata  output  8  store data, always equal to AC.
REQ-009 mem_we  output  1  memory write strobe, one cycle.
REQ-010 alu_opcode  output  8  IR contents driven to the ALU.
REQ-011 alu_value  output  8  OPR contents, the immediate operand.
REQ-012 alu_mdr  output  8  MDR contents.
REQ-013 ac  output  8  accumulator, signed.
REQ-014 alu_z  input  8  ALU result.
REQ-015 nflg, zflg  input  1 each  ALU flags, derived from ac.
REQ-016 pc  output  8  program counter, for debug.
REQ-017 halted  output  1  high while in HALT.

Function
REQ-018 Instruction format: 2 bytes, opcode at PC, operand at PC+1; all PC arithmetic is 8-bit modulo 256 (FF+1 = 00).
REQ-019 FSM states: FETCH1, FETCH2, READ, EXEC, HALT.
REQ-020 FETCH1: mem_addr = PC; if run=1: IR <= mem_rdata, PC <= PC+1, next FETCH2; else all registers hold.
REQ-021 FETCH2: mem_addr = PC; OPR <= mem_rdata, PC <= PC+1.
  - Next state is HALT if IR = FF.
  - Next state is READ if IR is one of 01, 05, 07, 09, 0A, 0B, 0C, 0D.
  - Otherwise next state is EXEC.
REQ-022 READ: mem_addr = OPR; MDR <= mem_rdata; next EXEC.
REQ-023 EXEC: mem_addr = OPR; next FETCH1; action by IR:
  - AC <= alu_z for IR in {01, 02, 04..0F}.
  - IR = 03: mem_we = 1, mem_addr = OPR, mem_wdata = AC.
  - IR = 10: PC <= OPR (JMP).
  - IR = 11: PC <= OPR if nflg = 1 (JN).
  - IR = 12: PC <= OPR if zflg = 1 (JZ).
  - IR = 00 and all other opcodes: no state change except the FSM step.
REQ-024 AC is never written for 00, 03, 10-12, or undefined opcodes, even though alu_z reads 00 for them.
REQ-025 mem_we is high only in EXEC with IR = 03; it is low in every other state and cycle.
REQ-026 Cycle counts from FETCH1 with run=1:
  - Immediate, store, branch, NOP and undefined opcodes: 3 cycles.
  - Memory-operand opcodes: 4 cycles.
  - FF reaches HALT after 2 cycles.
REQ-027 HALT: mem_addr = PC, halted = 1, mem_we = 0, all registers hold; only reset exits HALT.
REQ-028 Branch flags are the values nflg/zflg hold in the EXEC cycle, which reflect the AC before EXEC.
REQ-029 Fetch wrap: an opcode at FF takes its operand from 00, and PC continues at 01.

Reset
REQ-030 When reset=1 at a clock edge, the following registers are loaded:
  - state = FETCH1, PC = RESET_PC.
  - AC, IR, OPR, MDR = 00.
REQ-031 After that edge the outputs are halted = 0 and mem_we = 0.
REQ-032 Reset takes priority over run and over every FSM transition.
REQ-033 Reset in any state, including mid-instruction, aborts the instruction with no AC or memory update on that edge.

Verification
REQ-034 Program at 00: 02 05, 06 03, 03 20, FF 00, with run=1 -> mem[20]=08 written in cycle 8; ac=08; halted=1 from cycle 11 onward; pc=08.
REQ-035 mem[30]=FE; program 01 30, 05 30 -> ac=FE after 4 cycles, ac=FC after 8 cycles; nflg=1, mem_we never high.
REQ-036 Program 04 00, 12 40 -> pc=40 after 6 cycles; program 02 01, 12 40 -> pc=04 after 6 cycles (not taken).
REQ-037 run=0 for 5 cycles then 1 -> pc stays 00 and ac stays 00 during the stall; execution then matches the run=1 timing shifted by 5 cycles.
REQ-038 Reset asserted during EXEC of 03 20 -> mem_we stays 0 on that cycle; next cycle pc=00, ac=00, state FETCH1.
REQ-039 RESET_PC=FF, mem[FF]=02, mem[00]=7F -> ac=7F after 3 cycles, pc=01; undefined opcode 13 then leaves ac=7F and takes 3 cycles.
